// File: rtl/prco_mmio_uart_tx_pkg.sv
// ============================================================================
// prco_mmio_uart_tx_pkg
// Shared constants for the MMIO UART transmitter: register offsets, STATUS
// bit positions, serialiser state encoding and the STATUS word packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package prco_mmio_uart_tx_pkg;

  localparam logic [15:0] UART_OFF_TXDATA = 16'd0;
  localparam logic [15:0] UART_OFF_STATUS = 16'd1;

  localparam int STATUS_EMPTY  = 0;
  localparam int STATUS_FULL   = 1;
  localparam int STATUS_BUSY   = 2;
  localparam int STATUS_OVF    = 3;
  localparam int OVF_CLEAR_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic [15:0] uart_status_word(input logic ovf,
                                                   input logic busy,
                                                   input logic full,
                                                   input logic empty);
    logic [15:0] sw;
    sw               = 16'h0000;
    sw[STATUS_OVF]   = ovf;
    sw[STATUS_BUSY]  = busy;
    sw[STATUS_FULL]  = full;
    sw[STATUS_EMPTY] = empty;
    return sw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prco_sync_fifo.sv
// ============================================================================
// prco_sync_fifo
// Single-clock FIFO with registered full/empty flags; the head entry is
// presented on q_dout whenever the FIFO is not empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prco_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] q_dout,
  output logic             q_full,
  output logic             q_empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Flags are registered, so a push in the same cycle as a pop on a full
  // FIFO is still refused.
  assign w_do_push = i_push & ~full_q;
  assign w_do_pop  = i_pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (w_do_push && !w_do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (w_do_pop && !w_do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  assign q_dout  = mem_q[rd_ptr_q];
  assign q_full  = full_q;
  assign q_empty = empty_q;

endmodule

`default_nettype wire

// File: rtl/prco_mmio_uart_tx.sv
// ============================================================================
// prco_mmio_uart_tx
// Memory-mapped UART transmitter: TXDATA stores feed a byte FIFO that is
// serialised LSB-first; STATUS reports FIFO, line and overflow state.
// Optional even parity bit when PRCO_UART_PARITY_EN is defined (8E1),
// otherwise 8N1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prco_mmio_uart_tx
  import prco_mmio_uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] ADDR_BASE    = 16'hFF00
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_din,
  output logic        q_ce,
  output logic [15:0] q_dout,
  output logic        q_tx,
  output logic        q_busy
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [15:0]       ADDR_TXDATA = ADDR_BASE + UART_OFF_TXDATA;
  localparam logic [15:0]       ADDR_STATUS = ADDR_BASE + UART_OFF_STATUS;

  logic              w_sel_tx;
  logic              w_sel_st;
  logic              w_hit;
  logic              w_wr_tx;
  logic              w_wr_st;
  logic              w_rd_st;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_busy_fsm;
  logic              w_baud_end;
  logic [7:0]        w_fifo_dout;
  logic              unused_din;

  logic              ce_q;
  logic [15:0]       dout_q;
  logic              ovf_q;
  logic              busy_q;
  logic              tx_q;
  uart_state_e       state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
`ifdef PRCO_UART_PARITY_EN
  logic              par_q;
`endif

  assign w_sel_tx   = (i_addr == ADDR_TXDATA);
  assign w_sel_st   = (i_addr == ADDR_STATUS);
  assign w_hit      = i_ce & (w_sel_tx | w_sel_st);
  assign w_wr_tx    = w_hit & i_we & w_sel_tx;
  assign w_wr_st    = w_hit & i_we & w_sel_st;
  assign w_rd_st    = w_hit & ~i_we & w_sel_st;
  assign w_busy_fsm = (state_q != ST_IDLE);
  assign w_pop      = (state_q == ST_IDLE) & ~w_empty;
  assign w_baud_end = (baud_q == BAUD_LAST);
  assign unused_din = ^i_din[15:8];

  prco_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_wr_tx),
    .i_pop     (w_pop),
    .i_din     (i_din[7:0]),
    .q_dout    (w_fifo_dout),
    .q_full    (w_full),
    .q_empty   (w_empty)
  );

  // Bus side: one-cycle ack, read data only for STATUS, zero otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ce_q   <= 1'b0;
      dout_q <= 16'h0000;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ce_q   <= w_hit;
      dout_q <= w_rd_st ? uart_status_word(ovf_q, w_busy_fsm, w_full, w_empty)
                        : 16'h0000;
      if (w_wr_tx && w_full) begin
        ovf_q <= 1'b1;
      end else if (w_wr_st && i_din[OVF_CLEAR_BIT]) begin
        ovf_q <= 1'b0;
      end
      busy_q <= w_busy_fsm | ~w_empty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
`ifdef PRCO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!w_empty) begin
            state_q <= ST_START;
            baud_q  <= '0;
            shift_q <= w_fifo_dout;
            tx_q    <= 1'b0;
`ifdef PRCO_UART_PARITY_EN
            par_q   <= ^w_fifo_dout;
`endif
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            state_q <= ST_DATA;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef PRCO_UART_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= par_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`ifdef PRCO_UART_PARITY_EN
        ST_PARITY: begin
          if (w_baud_end) begin
            state_q <= ST_STOP;
            baud_q  <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`endif
        ST_STOP: begin
          // Returning to IDLE costs one clock, which is the inter-frame gap.
          if (w_baud_end) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
          tx_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign q_ce   = ce_q;
  assign q_dout = dout_q;
  assign q_tx   = tx_q;
  assign q_busy = busy_q;

endmodule

`default_nettype wire
